otp_rd_arbiter: RTL and testbench
=================================

Name: otp_rd_arbiter

Overview:
- Shares the single read port of the OTP program memory between two requesters: instruction fetch (IFU) and load/store (LSU).
- Sequences every OTP access: arbitration, issue, programmable wait states and response routing. An out-of-range access gets an error response and never touches the array.
- Sits between the core fetch/LSU interfaces and the OTP macro. It drives the macro's address bus and read-enable (flash_i_ifu_enable).

Parameters:
- WAIT_CYCLES, 0, extra cycles between OTP issue and response (0..15); total accept-to-response latency = 1 + WAIT_CYCLES.
- OTP_WORDS, 51, number of 32-bit words implemented in the OTP; word index = addr[31:2].

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- ifu_req_valid  input  1  IFU read request.
- ifu_req_addr  input  32  IFU byte address.
- ifu_req_ready  output  1  IFU request accepted this cycle (valid & ready).
- ifu_rsp_valid  output  1  one-cycle pulse; IFU response data valid.
- ifu_rsp_data  output  32  IFU read data.
- ifu_rsp_err  output  1  IFU response is an error (out of range or misaligned).
- lsu_req_valid, lsu_req_addr, lsu_req_ready, lsu_rsp_valid, lsu_rsp_data, lsu_rsp_err: same as the IFU set, for the LSU.
- otp_pa  output  32  OTP byte address; driven only while otp_ren=1, else 0.
- otp_ren  output  1  OTP read enable (drives flash_i_ifu_enable); one-cycle pulse per access.
- otp_rdata  input  32  OTP data. Registered in the macro and valid from the cycle after otp_ren; held while otp_ren=0.
- busy  output  1  transaction outstanding (state WAIT).

Behaviour:
- States: IDLE, WAIT. 4-bit wait counter cnt, 1-bit owner, 1-bit err_q, 1-bit last_grant.
- Acceptance window: state==IDLE, or state==WAIT with cnt==0 (the response cycle). This gives back-to-back throughput of one access per cycle when WAIT_CYCLES=0.
- Arbitration in the acceptance window:
  - One valid requester: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted (round-robin).
  - The req_ready of the granted requester is 1 (combinational); the other's is 0.
  - last_grant updates to the granted requester on accept.
- Accept cycle, good address (addr[1:0]==0 and addr[31:2] < OTP_WORDS):
  - otp_ren=1, otp_pa=addr.
  - Next state WAIT, cnt=WAIT_CYCLES, owner=granted, err_q=0.
- Accept cycle, bad address (misaligned or index >= OTP_WORDS):
  - otp_ren=0, otp_pa=0.
  - Same state transition and timing, with err_q=1.
- WAIT, cnt>0: cnt decrements; no outputs change.
- WAIT, cnt==0 (response cycle):
  - owner's rsp_valid=1.
  - rsp_data = otp_rdata when err_q=0; 32'h0 when err_q=1. rsp_err=err_q.
  - The other requester's rsp_valid=0.
  - Next state: WAIT (cnt reloaded) if a new request is accepted in the same cycle, else IDLE.
- Responses have no backpressure; requesters must sink rsp_valid in the cycle it is asserted.
- Requests are not queued. A requester not granted holds valid and addr stable until its ready is seen.
- rsp_data/rsp_err are 0 whenever the matching rsp_valid=0.
- busy = (state==WAIT).
- Reset (async, any time including mid-transaction):
  - state=IDLE, cnt=0, owner=IFU, err_q=0, last_grant=LSU (IFU wins the first tie).
  - All outputs 0 while rst=1. The outstanding transaction is dropped with no response.
- Reset value of every output: 0.

Test Plan:
- WAIT_CYCLES=0; IFU requests addr 0x0, 0x4, 0x8 held valid every cycle (OTP preloaded with word index i = 0x1000+i) -> otp_ren high 3 consecutive cycles; ifu_rsp_valid on cycles 1,2,3 after first accept with data 0x1000, 0x1001, 0x1002; err=0.
- WAIT_CYCLES=3; LSU single read addr 0x10 -> otp_ren pulse once, busy=1 for 4 cycles, lsu_rsp_valid exactly 4 cycles after accept with 0x1004; ifu_req_ready=0 throughout.
- Both valid continuously after reset (IFU 0x0, LSU 0x20) -> grants alternate IFU, LSU, IFU, LSU; each response routed only to its owner with 0x1000 / 0x1008.
- LSU addr 0xCC (index 51) and IFU addr 0x2 -> no otp_ren; rsp_valid after 1+WAIT_CYCLES cycles with rsp_err=1, rsp_data=0.
- WAIT_CYCLES=3; assert rst two cycles after an IFU accept -> all outputs 0 immediately, no ifu_rsp_valid ever; after release, IFU wins a simultaneous IFU/LSU request.

Source files
------------

// File: rtl/otp_rd_arbiter.sv
// Round-robin arbiter sharing the OTP read port between IFU and LSU; accept-to-response latency 1+WAIT_CYCLES.
// No response backpressure; a losing or blocked requester holds its request until its ready is seen.
module otp_rd_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int OTP_WORDS   = 51
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    input  logic [31:0] ifu_req_addr,
    output logic        ifu_req_ready,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rsp_data,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    input  logic [31:0] lsu_req_addr,
    output logic        lsu_req_ready,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rsp_data,
    output logic        lsu_rsp_err,
    output logic [31:0] otp_pa,
    output logic        otp_ren,
    input  logic [31:0] otp_rdata,
    output logic        busy
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    localparam logic        OWN_IFU = 1'b0;
    localparam logic        OWN_LSU = 1'b1;
    localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
    localparam logic [29:0] WORDS   = 30'(OTP_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic        last_grant_q, last_grant_d;

    logic        rsp_cyc;
    logic        in_win;
    logic        grant_lsu;
    logic        accept;
    logic        addr_ok;
    logic [31:0] sel_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_IFU;
            err_q        <= 1'b0;
            last_grant_q <= OWN_LSU;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            err_q        <= err_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        err_d        = err_q;
        last_grant_d = last_grant_q;

        rsp_cyc = (state_q == S_WAIT) && (cnt_q == 4'd0);
        // The response cycle doubles as an acceptance slot for full throughput.
        // Ready is combinational from valid, so it must be masked while reset is held.
        in_win  = !rst && ((state_q == S_IDLE) || (cnt_q == 4'd0));

        if (ifu_req_valid && lsu_req_valid) begin
            grant_lsu = (last_grant_q == OWN_IFU);
        end else begin
            grant_lsu = lsu_req_valid;
        end

        accept   = in_win && (ifu_req_valid || lsu_req_valid);
        sel_addr = grant_lsu ? lsu_req_addr : ifu_req_addr;
        addr_ok  = (sel_addr[1:0] == 2'b00) && (sel_addr[31:2] < WORDS);

        if (accept) begin
            state_d      = S_WAIT;
            cnt_d        = WAIT_LD;
            owner_d      = grant_lsu;
            err_d        = !addr_ok;
            last_grant_d = grant_lsu;
        end else if (rsp_cyc) begin
            state_d = S_IDLE;
        end else if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end

        ifu_req_ready = accept && !grant_lsu;
        lsu_req_ready = accept && grant_lsu;

        // Bad addresses still take a slot but never reach the array.
        otp_ren = accept && addr_ok;
        otp_pa  = otp_ren ? sel_addr : 32'h0;

        ifu_rsp_valid = rsp_cyc && (owner_q == OWN_IFU);
        lsu_rsp_valid = rsp_cyc && (owner_q == OWN_LSU);
        ifu_rsp_err   = ifu_rsp_valid && err_q;
        lsu_rsp_err   = lsu_rsp_valid && err_q;
        ifu_rsp_data  = (ifu_rsp_valid && !err_q) ? otp_rdata : 32'h0;
        lsu_rsp_data  = (lsu_rsp_valid && !err_q) ? otp_rdata : 32'h0;

        busy = (state_q == S_WAIT);
    end

endmodule

// File: tb/tb_otp_rd_arbiter.sv
// Bench for otp_rd_arbiter: two instances (WAIT_CYCLES 0 and 3) share stimulus and are
// compared every cycle against a cycle-count based reference model, plus directed literal checks.
module tb_otp_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_v, lsu_v;
    logic [31:0] ifu_a, lsu_a;

    logic        o_irdy [2];
    logic        o_ivld [2];
    logic        o_ierr [2];
    logic        o_lrdy [2];
    logic        o_lvld [2];
    logic        o_lerr [2];
    logic        o_ren  [2];
    logic        o_busy [2];
    logic [31:0] o_idat [2];
    logic [31:0] o_ldat [2];
    logic [31:0] o_pa   [2];
    logic [31:0] rd     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    otp_rd_arbiter #(.WAIT_CYCLES(0), .OTP_WORDS(51)) u_w0 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_v), .ifu_req_addr(ifu_a), .ifu_req_ready(o_irdy[0]),
        .ifu_rsp_valid(o_ivld[0]), .ifu_rsp_data(o_idat[0]), .ifu_rsp_err(o_ierr[0]),
        .lsu_req_valid(lsu_v), .lsu_req_addr(lsu_a), .lsu_req_ready(o_lrdy[0]),
        .lsu_rsp_valid(o_lvld[0]), .lsu_rsp_data(o_ldat[0]), .lsu_rsp_err(o_lerr[0]),
        .otp_pa(o_pa[0]), .otp_ren(o_ren[0]), .otp_rdata(rd[0]), .busy(o_busy[0])
    );

    otp_rd_arbiter #(.WAIT_CYCLES(3), .OTP_WORDS(51)) u_w3 (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_v), .ifu_req_addr(ifu_a), .ifu_req_ready(o_irdy[1]),
        .ifu_rsp_valid(o_ivld[1]), .ifu_rsp_data(o_idat[1]), .ifu_rsp_err(o_ierr[1]),
        .lsu_req_valid(lsu_v), .lsu_req_addr(lsu_a), .lsu_req_ready(o_lrdy[1]),
        .lsu_rsp_valid(o_lvld[1]), .lsu_rsp_data(o_ldat[1]), .lsu_rsp_err(o_lerr[1]),
        .otp_pa(o_pa[1]), .otp_ren(o_ren[1]), .otp_rdata(rd[1]), .busy(o_busy[1])
    );

    // OTP macro stand-ins: word i holds 0x1000+i, registered on read enable.
    initial begin
        rd[0] = 32'h0;
        rd[1] = 32'h0;
    end
    always @(posedge clk) if (o_ren[0]) rd[0] <= 32'h1000 + (o_pa[0] >> 2);
    always @(posedge clk) if (o_ren[1]) rd[1] <= 32'h1000 + (o_pa[1] >> 2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        ifu_v = 1'b0;
        lsu_v = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 19) == 0) begin
            a = $urandom;
        end else begin
            a = 32'($urandom_range(0, 55)) * 4;
            if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
        end
        return a;
    endfunction

    // Reference model: an outstanding access is remembered with the cycle its response is due.
    bit          mb   [2];
    int          due  [2];
    bit          mown [2];
    bit          merr [2];
    bit          mlg  [2];
    logic [31:0] mdat [2];
    int          cyc = 0;

    initial begin
        for (int k = 0; k < 2; k++) begin
            mb[k] = 0; mlg[k] = 1; mown[k] = 0; merr[k] = 0; mdat[k] = 0; due[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                bit          resp, win, acc, g, good;
                logic [31:0] a;
                int          wc;
                wc = (k == 0) ? 0 : 3;
                if (rst) begin
                    mb[k]  = 0;
                    mlg[k] = 1;
                end
                resp = !rst && mb[k] && (cyc == due[k]);
                win  = !rst && (!mb[k] || resp);
                g    = (ifu_v && lsu_v) ? !mlg[k] : lsu_v;
                a    = g ? lsu_a : ifu_a;
                good = (a % 4 == 0) && (a / 4 < 51);
                acc  = win && (ifu_v || lsu_v);

                chk($sformatf("w%0d.ifu_req_ready", wc), 32'(o_irdy[k]), 32'(acc && !g));
                chk($sformatf("w%0d.lsu_req_ready", wc), 32'(o_lrdy[k]), 32'(acc && g));
                chk($sformatf("w%0d.otp_ren", wc), 32'(o_ren[k]), 32'(acc && good));
                chk($sformatf("w%0d.otp_pa", wc), o_pa[k], (acc && good) ? a : 32'h0);
                chk($sformatf("w%0d.busy", wc), 32'(o_busy[k]), 32'(mb[k]));
                chk($sformatf("w%0d.ifu_rsp_valid", wc), 32'(o_ivld[k]), 32'(resp && !mown[k]));
                chk($sformatf("w%0d.lsu_rsp_valid", wc), 32'(o_lvld[k]), 32'(resp && mown[k]));
                chk($sformatf("w%0d.ifu_rsp_err", wc), 32'(o_ierr[k]), 32'(resp && !mown[k] && merr[k]));
                chk($sformatf("w%0d.lsu_rsp_err", wc), 32'(o_lerr[k]), 32'(resp && mown[k] && merr[k]));
                chk($sformatf("w%0d.ifu_rsp_data", wc), o_idat[k],
                    (resp && !mown[k] && !merr[k]) ? mdat[k] : 32'h0);
                chk($sformatf("w%0d.lsu_rsp_data", wc), o_ldat[k],
                    (resp && mown[k] && !merr[k]) ? mdat[k] : 32'h0);

                if (acc) begin
                    mb[k]   = 1;
                    due[k]  = cyc + 1 + wc;
                    mown[k] = g;
                    merr[k] = !good;
                    mdat[k] = good ? 32'h1000 + a / 4 : 32'h0;
                    mlg[k]  = g;
                end else if (resp) begin
                    mb[k] = 0;
                end
            end
            cyc++;
        end
    end

    initial begin
        rst   = 1'b1;
        ifu_v = 1'b1;
        lsu_v = 1'b1;
        ifu_a = 32'h0;
        lsu_a = 32'h0;
        @(negedge clk);
        chk("rst_ifu_ready", 32'(o_irdy[0]), 32'h0);
        chk("rst_otp_ren", 32'(o_ren[0]), 32'h0);
        chk("rst_busy", 32'(o_busy[1]), 32'h0);
        step();
        ifu_v = 1'b0;
        lsu_v = 1'b0;
        step();
        rst = 1'b0;

        // Back-to-back IFU reads with zero wait states
        ifu_v = 1'b1; ifu_a = 32'h0;
        @(negedge clk);
        chk("t1_ren_c0", 32'(o_ren[0]), 32'h1);
        chk("t1_pa_c0", o_pa[0], 32'h0);
        step(); ifu_a = 32'h4;
        @(negedge clk);
        chk("t1_pa_c1", o_pa[0], 32'h4);
        chk("t1_vld_c1", 32'(o_ivld[0]), 32'h1);
        chk("t1_dat_c1", o_idat[0], 32'h1000);
        step(); ifu_a = 32'h8;
        @(negedge clk);
        chk("t1_pa_c2", o_pa[0], 32'h8);
        chk("t1_dat_c2", o_idat[0], 32'h1001);
        step(); ifu_v = 1'b0;
        @(negedge clk);
        chk("t1_ren_c3", 32'(o_ren[0]), 32'h0);
        chk("t1_vld_c3", 32'(o_ivld[0]), 32'h1);
        chk("t1_dat_c3", o_idat[0], 32'h1002);
        chk("t1_err_c3", 32'(o_ierr[0]), 32'h0);
        step();

        // Single LSU read with three wait states
        do_reset();
        lsu_v = 1'b1; lsu_a = 32'h10;
        @(negedge clk);
        chk("t2_ren", 32'(o_ren[1]), 32'h1);
        chk("t2_lsu_ready", 32'(o_lrdy[1]), 32'h1);
        chk("t2_busy_c0", 32'(o_busy[1]), 32'h0);
        step(); lsu_v = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("t2_busy_c%0d", i), 32'(o_busy[1]), 32'h1);
            chk($sformatf("t2_vld_c%0d", i), 32'(o_lvld[1]), 32'(i == 4));
            chk($sformatf("t2_ren_c%0d", i), 32'(o_ren[1]), 32'h0);
            if (i == 4) chk("t2_dat", o_ldat[1], 32'h1004);
            step();
        end
        @(negedge clk);
        chk("t2_busy_c5", 32'(o_busy[1]), 32'h0);

        // Continuous contention alternates grants starting with IFU
        do_reset();
        ifu_v = 1'b1; ifu_a = 32'h0;
        lsu_v = 1'b1; lsu_a = 32'h20;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("t3_ifu_rdy_c%0d", i), 32'(o_irdy[0]), 32'(i % 2 == 0));
            chk($sformatf("t3_lsu_rdy_c%0d", i), 32'(o_lrdy[0]), 32'(i % 2 == 1));
            if (i > 0) begin
                chk($sformatf("t3_ifu_vld_c%0d", i), 32'(o_ivld[0]), 32'(i % 2 == 1));
                chk($sformatf("t3_lsu_vld_c%0d", i), 32'(o_lvld[0]), 32'(i % 2 == 0));
                if (i % 2 == 1) chk($sformatf("t3_ifu_dat_c%0d", i), o_idat[0], 32'h1000);
                else            chk($sformatf("t3_lsu_dat_c%0d", i), o_ldat[0], 32'h1008);
            end
            step();
        end
        ifu_v = 1'b0; lsu_v = 1'b0;

        // Misaligned and out-of-range accesses
        do_reset();
        ifu_v = 1'b1; ifu_a = 32'h2;
        @(negedge clk);
        chk("t4_ren_w0", 32'(o_ren[0]), 32'h0);
        chk("t4_ren_w3", 32'(o_ren[1]), 32'h0);
        chk("t4_ifu_rdy", 32'(o_irdy[0]), 32'h1);
        step(); ifu_v = 1'b0; lsu_v = 1'b1; lsu_a = 32'hCC;
        @(negedge clk);
        chk("t4_ifu_vld", 32'(o_ivld[0]), 32'h1);
        chk("t4_ifu_err", 32'(o_ierr[0]), 32'h1);
        chk("t4_ifu_dat", o_idat[0], 32'h0);
        chk("t4_lsu_rdy", 32'(o_lrdy[0]), 32'h1);
        chk("t4_lsu_ren", 32'(o_ren[0]), 32'h0);
        step(); lsu_v = 1'b0;
        @(negedge clk);
        chk("t4_lsu_vld", 32'(o_lvld[0]), 32'h1);
        chk("t4_lsu_err", 32'(o_lerr[0]), 32'h1);
        chk("t4_lsu_dat", o_ldat[0], 32'h0);
        step();
        step();
        @(negedge clk);
        chk("t4_w3_vld", 32'(o_ivld[1]), 32'h1);
        chk("t4_w3_err", 32'(o_ierr[1]), 32'h1);
        chk("t4_w3_dat", o_idat[1], 32'h0);
        step();

        // Reset in the middle of an outstanding access
        do_reset();
        ifu_v = 1'b1; ifu_a = 32'h8;
        @(negedge clk);
        chk("t5_ren", 32'(o_ren[1]), 32'h1);
        step(); ifu_v = 1'b0;
        step(); rst = 1'b1;
        @(negedge clk);
        chk("t5_busy_rst", 32'(o_busy[1]), 32'h0);
        chk("t5_vld_rst", 32'(o_ivld[1]), 32'h0);
        step();
        step();
        rst = 1'b0;
        ifu_v = 1'b1; ifu_a = 32'h0;
        lsu_v = 1'b1; lsu_a = 32'h20;
        @(negedge clk);
        chk("t5_ifu_wins", 32'(o_irdy[1]), 32'h1);
        chk("t5_lsu_loses", 32'(o_lrdy[1]), 32'h0);
        step();
        ifu_v = 1'b0; lsu_v = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            ifu_v = ($urandom_range(0, 3) != 0);
            lsu_v = ($urandom_range(0, 3) != 0);
            ifu_a = rand_addr();
            lsu_a = rand_addr();
            step();
        end
        rst = 1'b0; ifu_v = 1'b0; lsu_v = 1'b0;
        step();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
